// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - single-wire frame receiver with frame buffer and byte-wise valid/ack drain
module serial_rx #(
    parameter int MAX_BYTES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [2:0] nbytes,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ack,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BUFW = 8 * MAX_BYTES;
    localparam int BW = $clog2(BUFW);
    localparam logic [2:0] MAX_N = 3'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, RECV, STOP, DRAIN} state_t;

    state_t          state;
    logic [2:0]      n;
    logic [2:0]      rdidx;
    logic [BW-1:0]   bitcnt;
    logic [BUFW-1:0] frame_buf;

    logic [2:0]      n_start;
    logic [2:0]      rd_next;
    logic [BW-1:0]   last_bit;
    logic            start_seen;

    assign n_start    = (nbytes > MAX_N) ? MAX_N : nbytes;
    assign rd_next    = rdidx + 3'd1;
    // 8n-1 written as {n-1, 3'b111}; only used in RECV where n is never zero
    assign last_bit   = BW'({n - 3'd1, 3'b111});
    assign start_seen = ((state == IDLE) || (state == DRAIN)) && !rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            rdidx     <= '0;
            bitcnt    <= '0;
            frame_buf <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (start_seen) begin
                // A new start bit always wins, dropping any undrained bytes
                overrun  <= (state == DRAIN);
                valid    <= 1'b0;
                data_out <= '0;
                n        <= n_start;
                bitcnt   <= '0;
                rdidx    <= '0;
                busy     <= 1'b1;
                state    <= (n_start != 3'd0) ? RECV : STOP;
            end else begin
                case (state)
                    RECV: begin
                        frame_buf[bitcnt] <= rx;
                        bitcnt            <= bitcnt + BW'(1);
                        if (bitcnt == last_bit)
                            state <= STOP;
                    end
                    STOP: begin
                        if (rx && (n != 3'd0)) begin
                            state    <= DRAIN;
                            valid    <= 1'b1;
                            data_out <= frame_buf[7:0];
                            rdidx    <= '0;
                        end else begin
                            frame_err <= !rx;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (ack) begin
                            if (rdidx == n - 3'd1) begin
                                valid    <= 1'b0;
                                data_out <= '0;
                                rdidx    <= '0;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                rdidx    <= rd_next;
                                data_out <= frame_buf[BW'({rd_next, 3'b000}) +: 8];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - table-driven frames plus directed backpressure, overrun and reset sequences
module tb_serial_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [2:0] nbytes;
    logic [7:0] data_out;
    logic       valid;
    logic       ack;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    serial_rx #(.MAX_BYTES(6)) dut (
        .clk(clk), .rst(rst), .rx(rx), .nbytes(nbytes),
        .data_out(data_out), .valid(valid), .ack(ack),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  nb;
        logic [47:0] data;
        int          nsend;
        logic        stop;
        int          exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start bit, nsend data bytes LSB-first, stop bit; returns just after the stop-bit edge
    task automatic send_frame(input logic [2:0] nb, input logic [47:0] d, input int nsend,
                              input logic stop);
        rx = 1'b0;
        nbytes = nb;
        tick();
        for (int i = 0; i < 8 * nsend; i++) begin
            rx = d[i];
            tick();
        end
        rx = stop;
        tick();
        rx = 1'b1;
    endtask

    task automatic drain(input string name, input logic [47:0] d, input int cnt);
        logic [7:0] b;
        ack = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            b = d[8*k +: 8];
            check({name, " valid"}, 32'(valid), 32'd1);
            check({name, " byte"}, 32'(data_out), 32'(b));
            tick();
        end
        ack = 1'b0;
        check({name, " valid after"}, 32'(valid), 32'd0);
        check({name, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"single_a5", 3'd1, 48'h0000_0000_00A5, 1, 1'b1, 1, 1'b0};
        vecs[1] = '{"full6",     3'd6, 48'hAB89_6745_2301, 6, 1'b1, 6, 1'b0};
        vecs[2] = '{"clamp7",    3'd7, 48'hF0E1_D2C3_B4A5, 6, 1'b1, 6, 1'b0};
        vecs[3] = '{"badstop",   3'd1, 48'h0000_0000_003C, 1, 1'b0, 0, 1'b1};
        vecs[4] = '{"zero_len",  3'd0, 48'h0000_0000_0000, 0, 1'b1, 0, 1'b0};
        vecs[5] = '{"three",     3'd3, 48'h0000_00FF_8001, 3, 1'b1, 3, 1'b0};

        rst = 1'b1; rx = 1'b1; nbytes = 3'd0; ack = 1'b0;
        tick();
        tick();
        check("rst valid", 32'(valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst data", 32'(data_out), 32'd0);
        check("rst flags", 32'({frame_err, overrun}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].nb, vecs[v].data, vecs[v].nsend, vecs[v].stop);
            check({vecs[v].name, " frame_err"}, 32'(frame_err), 32'(vecs[v].exp_err));
            check({vecs[v].name, " busy"}, 32'(busy), 32'(vecs[v].exp_cnt > 0));
            check({vecs[v].name, " overrun"}, 32'(overrun), 32'd0);
            if (vecs[v].exp_cnt == 0) begin
                check({vecs[v].name, " no valid"}, 32'(valid), 32'd0);
                tick();
                check({vecs[v].name, " err cleared"}, 32'(frame_err), 32'd0);
                check({vecs[v].name, " still no valid"}, 32'(valid), 32'd0);
                check({vecs[v].name, " idle"}, 32'(busy), 32'd0);
            end else begin
                drain(vecs[v].name, vecs[v].data, vecs[v].exp_cnt);
            end
            tick();
        end

        // Backpressure: first byte held stable while ack withheld
        send_frame(3'd2, 48'h2211, 2, 1'b1);
        for (int c = 0; c < 10; c++) begin
            check("bp hold data", 32'(data_out), 32'h11);
            check("bp hold valid", 32'(valid), 32'd1);
            tick();
        end
        drain("bp", 48'h2211, 2);

        // Overrun: undrained 2-byte frame replaced by a 1-byte frame 0x5A
        send_frame(3'd2, 48'hADDE, 2, 1'b1);
        check("ovr first valid", 32'(valid), 32'd1);
        tick();
        rx = 1'b0;
        nbytes = 3'd1;
        tick();
        check("ovr pulse", 32'(overrun), 32'd1);
        check("ovr valid dropped", 32'(valid), 32'd0);
        check("ovr busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rx = 1'(8'h5A >> i);
            tick();
            check("ovr pulse single", 32'(overrun), 32'd0);
            check("ovr no stale valid", 32'(valid), 32'd0);
        end
        rx = 1'b1;
        tick();
        drain("ovr new", 48'h5A, 1);
        tick();

        // Reset mid-RECV after 5 data bits
        rx = 1'b0;
        nbytes = 3'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            rx = 1'(i);
            tick();
        end
        rst = 1'b1;
        rx = 1'b1;
        tick();
        check("rst recv busy", 32'(busy), 32'd0);
        check("rst recv outs", 32'({valid, data_out, frame_err, overrun}), 32'd0);
        rst = 1'b0;
        tick();

        // Reset mid-DRAIN with valid high
        send_frame(3'd2, 48'h9977, 2, 1'b1);
        check("pre rst drain valid", 32'(valid), 32'd1);
        rst = 1'b1;
        tick();
        check("rst drain valid", 32'(valid), 32'd0);
        check("rst drain data", 32'(data_out), 32'd0);
        check("rst drain busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("post rst no valid", 32'(valid), 32'd0);

        send_frame(3'd1, 48'hC3, 1, 1'b1);
        drain("after rst", 48'hC3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Downstream stage of the serial transmitter. Receives its single-wire frame in the same clock domain, one bit per clk, no oversampling or baud divider.
- Deserialises up to MAX_BYTES bytes into a frame buffer.
- After a valid stop bit, presents the bytes one at a time, in transmit order, on a valid/ack handshake to the consuming logic.

Parameters:
MAX_BYTES, 6, maximum data bytes per frame (buffer is 8*MAX_BYTES bits)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
rx  input  1  serial line; idle high, driven by transmitter tx
nbytes  input  3  bytes expected in next frame; sampled with start bit; values >MAX_BYTES clamp to MAX_BYTES
data_out  output  8  current byte; valid only while valid=1
valid  output  1  data_out holds an unconsumed byte
ack  input  1  consumer takes data_out this cycle when valid=1
busy  output  1  high in any state other than IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: new start bit while bytes undrained

Behaviour:
- Frame format: 1 start bit (0), then 8*N data bits LSB-first (first bit is bit 0 of byte 0, bytes in order 0..N-1), then 1 stop bit (1). One bit per clk, back-to-back.
- rst=1 at a clock edge forces the following, also mid-frame and mid-drain:
  - state=IDLE
  - valid=0, data_out=0, busy=0, frame_err=0, overrun=0
  - buffer, bit counter and read index all 0
- Any buffered bytes are discarded on reset.
- States: IDLE, RECV, STOP, DRAIN.
- IDLE:
  - rx=0 sampled: latch n=min(nbytes,MAX_BYTES) and clear bitcnt.
  - Go to RECV if n>0, else go to STOP.
  - rx=1: stay.
- RECV:
  - Each cycle store rx at buf[bitcnt], then bitcnt+1.
  - When bitcnt==8n-1 (last bit stored this cycle), go to STOP.
  - bitcnt is wide enough for 8*MAX_BYTES; no wrap.
- STOP, rx=1:
  - n>0: go to DRAIN, set valid=1, data_out=buf[7:0], rdidx=0. valid rises on the edge that samples the stop bit.
  - n=0: go to IDLE; no output.
- STOP, rx=0: pulse frame_err for one cycle, go to IDLE, discard the frame. That low sample is not treated as a start bit.
- DRAIN:
  - data_out=buf[8*rdidx+7:8*rdidx], held stable until ack.
  - ack=1: rdidx+1. If rdidx was n-1, valid=0 and go to IDLE; otherwise next byte is on data_out the following cycle.
  - ack while valid=0 is ignored in every state.
- DRAIN with rx=0 sampled (new start bit, any ack value):
  - overrun pulses one cycle, valid=0, remaining bytes dropped.
  - Latch new n and go to RECV/STOP exactly as from IDLE. The new frame always wins.
- busy=1 in RECV, STOP and DRAIN.
- Bytes beyond n in buf are don't-care and never presented.
- Transmitter idle after its stop bit (tx stays 1) produces no activity.

Test Plan:
1. Single byte: reset, nbytes=1, drive frame 0, bits of 0xA5 LSB-first, 1 → valid rises on the stop-bit edge, data_out=0xA5; ack one cycle → valid=0, busy=0.
2. Full frame: nbytes=6, send 0x01,0x23,0x45,0x67,0x89,0xAB, ack held high → data_out sequence 0x01..0xAB on consecutive cycles, valid low after the 6th.
3. Backpressure and clamp:
   - ack withheld 10 cycles → data_out stable at first byte, valid held.
   - nbytes=7 → frame of 48 data bits accepted as 6 bytes.
4. Bad stop and zero-length:
   - 0x3C frame with stop bit 0 → frame_err single pulse, valid never rises, state IDLE next cycle.
   - nbytes=0 frame "0,1" → no valid, no error.
5. Overrun: 2-byte frame received, ack nothing, start new 1-byte frame 0x5A → overrun pulse on start bit; 0x5A delivered next; old bytes never appear.
6. Reset mid-RECV after 5 bits and mid-DRAIN with valid=1 → all outputs 0 next cycle; subsequent clean frame 0xC3 received correctly.
